pipelined_cla_addsub: RTL and testbench



---
 rtl/pipelined_cla_addsub.sv | 178 +++++++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry look-ahead adder/subtractor.
// The WIDTH-bit operation is split into NSTG = WIDTH/GROUP groups. Stage k
// resolves group k with an in-group look-ahead carry network and registers
// the group carry for stage k+1. Lower result bits ride along in registers.
// Optional build macro PCLA_SATURATE_EN: on signed overflow the result is
// clamped to the signed extreme selected by operand A's sign.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready.
// Stage k advances when it holds data and the stage after it is empty or
// advancing itself; the last stage advances on out_ready. in_ready is
// therefore combinational from out_ready through the valid chain, and a
// stalled stage holds every one of its registers.
module pipelined_cla_addsub #(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);

    localparam int NSTG = WIDTH / GROUP;

    if (GROUP < 1 || (WIDTH % GROUP) != 0) begin : g_param_check
        $error("pipelined_cla_addsub: WIDTH must be a positive multiple of GROUP");
    end

    // Look-ahead carries of one group: c[j+1] = g[j] | p[j]g[j-1] | ... | p[j..0]cin.
    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                   input logic [GROUP-1:0] p,
                                                   input logic             c_in);
        logic [GROUP:0] c;
        logic           prop;
        c    = '0;
        c[0] = c_in;
        for (int j = 0; j < GROUP; j++) begin
            prop     = p[j];
            c[j+1]   = g[j];
            for (int i = j - 1; i >= 0; i--) begin
                c[j+1] = c[j+1] | (prop & g[i]);
                prop   = prop & p[i];
            end
            c[j+1] = c[j+1] | (prop & c_in);
        end
        return c;
    endfunction

    // Operand conditioning: subtract is a + ~b + ~cin, i.e. a - b - cin.
    logic [WIDTH-1:0] bx_in;
    logic             c0;
    assign bx_in = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // Per-stage register views, one element driven by each stage.
    logic [NSTG-1:0]  vld;
    logic [NSTG-1:0]  c_q;
    logic [WIDTH-1:0] a_q  [NSTG];
    logic [WIDTH-1:0] bx_q [NSTG];
    logic [WIDTH-1:0] s_q  [NSTG];
    logic             ovf_q;
    logic             zero_q;

    // Advance chain, resolved from the output back towards the input.
    logic [NSTG-1:0] adv;
    always_comb begin
        logic down_free;
        adv       = '0;
        down_free = out_ready;
        for (int k = NSTG - 1; k >= 0; k--) begin
            adv[k]    = vld[k] && down_free;
            down_free = !vld[k] || adv[k];
        end
        in_ready = down_free;
    end

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] bx_src;
        logic [WIDTH-1:0] s_src;
        logic             c_src;
        logic             load;
        logic [GROUP-1:0] ga;
        logic [GROUP-1:0] gb;
        logic [GROUP:0]   cc;
        logic [WIDTH-1:0] s_new;
        logic             vld_r;
        logic             c_r;
        logic [WIDTH-1:0] a_r;
        logic [WIDTH-1:0] bx_r;
        logic [WIDTH-1:0] s_r;

        if (k == 0) begin : g_first
            assign a_src  = a;
            assign bx_src = bx_in;
            assign s_src  = '0;
            assign c_src  = c0;
            assign load   = in_valid && in_ready;
        end else begin : g_next
            assign a_src  = a_q[k-1];
            assign bx_src = bx_q[k-1];
            assign s_src  = s_q[k-1];
            assign c_src  = c_q[k-1];
            assign load   = adv[k-1];
        end

        assign ga = a_src[k*GROUP +: GROUP];
        assign gb = bx_src[k*GROUP +: GROUP];
        assign cc = cla_carries(ga & gb, ga ^ gb, c_src);

        // Merge this group's sum bits into the bits already resolved upstream.
        always_comb begin
            s_new = s_src;
            s_new[k*GROUP +: GROUP] = ga ^ gb ^ cc[GROUP-1:0];
`ifdef PCLA_SATURATE_EN
            if (k == NSTG - 1 && (cc[GROUP] ^ cc[GROUP-1])) begin
                s_new = a_src[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
            end
`endif
        end

        // Stage register: load from upstream, empty when drained, else hold.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                vld_r <= 1'b0;
                c_r   <= 1'b0;
                a_r   <= '0;
                bx_r  <= '0;
                s_r   <= '0;
            end else if (load) begin
                vld_r <= 1'b1;
                c_r   <= cc[GROUP];
                a_r   <= a_src;
                bx_r  <= bx_src;
                s_r   <= s_new;
            end else if (adv[k]) begin
                vld_r <= 1'b0;
            end
        end

        assign vld[k]  = vld_r;
        assign c_q[k]  = c_r;
        assign a_q[k]  = a_r;
        assign bx_q[k] = bx_r;
        assign s_q[k]  = s_r;

        if (k == NSTG - 1) begin : g_last
            // Flags are registered together with the final group.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (load) begin
                    ovf_q  <= cc[GROUP] ^ cc[GROUP-1];
                    zero_q <= (s_new == '0);
                end
            end
        end
    end

    assign out_valid = vld[NSTG-1];
    assign sum       = s_q[NSTG-1];
    assign cout      = c_q[NSTG-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub (WIDTH=32, GROUP=8): directed vectors with
// hand-computed results, backpressure with out_ready pattern 1,0,0,1, and
// an asynchronous reset while operations are in flight.
module tb_pipelined_cla_addsub;
  localparam int W    = 32;
  localparam int NSTG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          sub;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          overflow;
  logic          zero;

  int n_checks = 0;
  int n_fail   = 0;

  // expected {overflow, zero, cout, sum}
  logic [W+2:0] exp_q[$];
  logic [W+2:0] prev_out;
  logic         prev_stall = 1'b0;
  logic         saw_full   = 1'b0;
  logic         bp_mode    = 1'b0;
  logic [3:0]   bp_pat     = 4'b1001;
  int           bp_idx     = 0;

  pipelined_cla_addsub #(.WIDTH(W), .GROUP(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [W+2:0] pack(input logic o, input logic z, input logic c, input logic [W-1:0] s);
    return {o, z, c, s};
  endfunction

  // Independent arithmetic model used for the random backpressure traffic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                         input logic ms, input logic mc);
    logic [W-1:0] bx;
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         ov;
    bx   = ms ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bx} + {{W{1'b0}}, ms ^ mc};
    s    = full[W-1:0];
    ov   = (ma[W-1] == bx[W-1]) && (s[W-1] != ma[W-1]);
`ifdef PCLA_SATURATE_EN
    if (ov) s = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
    return {ov, (s == '0), full[W], s};
  endfunction

  // ---------------- scoreboard / monitor (sampled on negedge) ----------------
  always @(negedge clk) begin
    logic [W+2:0] e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check("in_ready", 64'(in_ready), 64'((exp_q.size() < NSTG) || out_ready));
      if (prev_stall)
        check("hold_stable", 64'({out_valid, overflow, zero, cout, sum}), 64'({1'b1, prev_out}));
      if (exp_q.size() == NSTG && !out_ready && !in_ready) saw_full = 1'b1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("sum",      64'(sum),      64'(e[W-1:0]));
          check("cout",     64'(cout),     64'(e[W]));
          check("zero",     64'(zero),     64'(e[W+1]));
          check("overflow", 64'(overflow), 64'(e[W+2]));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {overflow, zero, cout, sum};
    end
  end

  // out_ready pattern driver for the backpressure phase
  always @(posedge clk) begin
    if (bp_mode) begin
      #1;
      out_ready = bp_pat[bp_idx];
      bp_idx    = (bp_idx + 1) % 4;
    end
  end

  // ---------------- driver tasks (called and returning at posedge+1) ----------------
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic ts,
                      input logic tc, input logic [W+2:0] texp);
    int   waited = 0;
    logic acc    = 1'b0;
    a = ta; b = tb; sub = ts; cin = tc; in_valid = 1'b1;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      waited++;
      if (acc) exp_q.push_back(texp);
    end
    #1;
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (edge 1) until out_valid is seen.
  task automatic expect_latency(input string tag);
    int n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, 64'(n), 64'(NSTG));
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [W-1:0] va, vb;
    logic         vs, vc;
    logic [W-1:0] s_wrap, s_sat;
    logic         c, o, z_wrap, z_sat;
  } vec_t;
  vec_t vecs[7];

  initial begin
    vecs[0] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 32'h2143_6588, 32'h2143_6588, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 1'b0};
  end

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; cin = 1'b0; out_ready = 1'b1;

    // reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_sum",       64'(sum),       64'(0));
    check("rst_cout",      64'(cout),      64'(0));
    check("rst_overflow",  64'(overflow),  64'(0));
    check("rst_zero",      64'(zero),      64'(0));
    check("rst_in_ready",  64'(in_ready),  64'(1));
    @(posedge clk); #1;

    // carry through every group, with latency
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, pack(1'b0, 1'b1, 1'b1, 32'h0000_0000));
    expect_latency("latency_first");
    drain("drain_first");

    // directed vectors back to back
    for (int i = 0; i < 7; i++) begin
`ifdef PCLA_SATURATE_EN
      send(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vc, pack(vecs[i].o, vecs[i].z_sat, vecs[i].c, vecs[i].s_sat));
`else
      send(vecs[i].va, vecs[i].vb, vecs[i].vs, vecs[i].vc, pack(vecs[i].o, vecs[i].z_wrap, vecs[i].c, vecs[i].s_wrap));
`endif
    end
    drain("drain_directed");

    // backpressure: 10 back-to-back ops, out_ready 1,0,0,1
    bp_idx  = 0;
    bp_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      logic [W-1:0] ra, rb;
      logic         rs, rc;
      ra = $urandom();
      rb = $urandom();
      rs = 1'($urandom_range(0, 1));
      rc = 1'($urandom_range(0, 1));
      send(ra, rb, rs, rc, model(ra, rb, rs, rc));
    end
    drain("drain_backpressure");
    check("bp_saw_full", 64'(saw_full), 64'(1));
    bp_mode = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;

    // reset while three ops are in flight
    out_ready = 1'b0;
    send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'h0000_0003));
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'h0000_0030));
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'h0000_0300));
    @(posedge clk); #1;
    check("pre_rst_out_valid", 64'(out_valid), 64'(1));
    #3;
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", 64'(out_valid), 64'(0));
    check("async_rst_sum",       64'(sum),       64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("post_rst_idle", 64'(out_valid), 64'(0));
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, pack(1'b0, 1'b0, 1'b0, 32'h0000_0100));
    expect_latency("latency_after_rst");
    drain("drain_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // global time bound
  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
